scaler_h_mch: RTL and testbench

SCALER_H_MCH -- requirements
Module: scaler_h_mch

---
 rtl/scaler_h_mch_if.sv | 27 ++
 rtl/scaler_h_mch.sv | 183 ++++++++++++++++++
 tb/tb_scaler_h_mch.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/scaler_h_mch_if.sv
// Pixel stream bundle for the horizontal scaler: input sample/sync, output sample/sync, error flag.
interface scaler_h_mch_if #(
  parameter int CHANNELS    = 1,
  parameter int PIXEL_WIDTH = 8,
  parameter int STEP_WIDTH  = 16
);
  logic [STEP_WIDTH-1:0]           scale_step;
  logic [CHANNELS*PIXEL_WIDTH-1:0] di_i;
  logic                            de_i;
  logic                            hs_i;
  logic                            vs_i;
  logic [CHANNELS*PIXEL_WIDTH-1:0] do_o;
  logic                            de_o;
  logic                            hs_o;
  logic                            vs_o;
  logic                            err_o;

  modport master (
    output scale_step, di_i, de_i, hs_i, vs_i,
    input  do_o, de_o, hs_o, vs_o, err_o
  );

  modport slave (
    input  scale_step, di_i, de_i, hs_i, vs_i,
    output do_o, de_o, hs_o, vs_o, err_o
  );
endinterface

// File: rtl/scaler_h_mch.sv
// Horizontal multi-channel linear scaler; 3 cycles from pixel acceptance to its first output.
// No backpressure: a one-entry hold absorbs a pixel during emission, further pixels drop and set err_o.
module scaler_h_mch #(
  parameter int CHANNELS    = 1,
  parameter int PIXEL_WIDTH = 8,
  parameter int PIXEL_STEP  = 128,
  parameter int STEP_WIDTH  = 16,
  parameter int MAX_LINE    = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  scaler_h_mch_if.slave  bus
);
  localparam int W_BITS    = $clog2(PIXEL_STEP);
  localparam int WW        = W_BITS + 1;
  localparam int LINE_BITS = $clog2(MAX_LINE * PIXEL_STEP + 1);
  localparam int POS_W     = ((LINE_BITS > STEP_WIDTH) ? LINE_BITS : STEP_WIDTH) + 1;
  localparam int SW        = PIXEL_WIDTH + WW + 1;
  localparam int DW        = CHANNELS * PIXEL_WIDTH;
  localparam logic [POS_W-1:0] STEP_P  = POS_W'(PIXEL_STEP);
  localparam logic [WW-1:0]    STEP_WT = WW'(PIXEL_STEP);

  typedef enum logic [1:0] {IDLE, SEG, EMIT} state_t;
  state_t state, state_nx;

  logic                  armed;
  logic [STEP_WIDTH-1:0] step_r;
  logic [POS_W-1:0]      pos, seg_end, pos_nx;
  logic [DW-1:0]         cur, prev, hold_dat, ld_dat;
  logic                  hold_vld;
  logic                  in_seg, seg_done;
  logic                  ld, ld_hold, first, hold_set, hold_take, ovf, fire;

  logic                  s1_vld;
  logic [WW-1:0]         s1_w;
  logic [DW-1:0]         s1_a, s1_b, mix, do_r;
  logic                  de_r, err_r;
  logic [2:0]            hs_pipe, vs_pipe;

  // pos is the next output position; seg_end is n*PIXEL_STEP for the current pixel
  assign pos_nx   = pos + POS_W'(step_r);
  assign in_seg   = (pos <= seg_end);
  assign seg_done = !in_seg || (pos_nx > seg_end);
  assign ld_dat   = ld_hold ? hold_dat : bus.di_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Segment boundaries chain straight into the next pixel so one pixel per cycle is sustained
  always_comb begin
    state_nx  = state;
    ld        = 1'b0;
    ld_hold   = 1'b0;
    first     = 1'b0;
    hold_set  = 1'b0;
    hold_take = 1'b0;
    ovf       = 1'b0;
    fire      = 1'b0;
    if (bus.hs_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.de_i && armed) begin
          ld       = 1'b1;
          first    = 1'b1;
          state_nx = EMIT;
        end
        SEG: if (hold_vld) begin
          ld        = 1'b1;
          ld_hold   = 1'b1;
          hold_take = 1'b1;
          hold_set  = bus.de_i;
          state_nx  = EMIT;
        end else if (bus.de_i) begin
          ld       = 1'b1;
          state_nx = EMIT;
        end
        EMIT: begin
          fire = in_seg;
          if (seg_done) begin
            if (hold_vld) begin
              ld        = 1'b1;
              ld_hold   = 1'b1;
              hold_take = 1'b1;
              hold_set  = bus.de_i;
            end else if (bus.de_i) begin
              ld = 1'b1;
            end else begin
              state_nx = SEG;
            end
          end else if (bus.de_i) begin
            if (hold_vld) ovf      = 1'b1;
            else          hold_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      step_r   <= '0;
      pos      <= '0;
      seg_end  <= '0;
      cur      <= '0;
      prev     <= '0;
      hold_dat <= '0;
      hold_vld <= 1'b0;
    end else if (bus.hs_i) begin
      armed    <= 1'b1;
      step_r   <= (bus.scale_step == '0) ? STEP_WIDTH'(1) : bus.scale_step;
      pos      <= '0;
      seg_end  <= '0;
      hold_vld <= 1'b0;
    end else begin
      if (fire) pos <= pos_nx;
      if (ld) begin
        cur     <= ld_dat;
        prev    <= first ? ld_dat : cur;
        seg_end <= first ? '0 : seg_end + STEP_P;
      end
      if (hold_set) begin
        hold_dat <= bus.di_i;
        hold_vld <= 1'b1;
      end else if (hold_take) begin
        hold_vld <= 1'b0;
      end
    end
  end

  function automatic logic [PIXEL_WIDTH-1:0] blend(input logic [PIXEL_WIDTH-1:0] a,
                                                   input logic [PIXEL_WIDTH-1:0] b,
                                                   input logic [WW-1:0]          w);
    logic [SW-1:0] acc;
    acc = SW'(a) * SW'(STEP_WT - w) + SW'(b) * SW'(w) + SW'(PIXEL_STEP / 2);
    return PIXEL_WIDTH'(acc >> W_BITS);
  endfunction

  always_comb begin
    mix = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      mix[k*PIXEL_WIDTH +: PIXEL_WIDTH] = blend(s1_a[k*PIXEL_WIDTH +: PIXEL_WIDTH],
                                                s1_b[k*PIXEL_WIDTH +: PIXEL_WIDTH], s1_w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_w    <= '0;
      s1_a    <= '0;
      s1_b    <= '0;
      de_r    <= 1'b0;
      do_r    <= '0;
      err_r   <= 1'b0;
      hs_pipe <= '0;
      vs_pipe <= '0;
    end else begin
      s1_vld <= fire;
      if (fire) begin
        // pixel 0 has seg_end 0 and pos 0, giving a full weight on itself
        s1_w <= WW'(pos + STEP_P - seg_end);
        s1_a <= prev;
        s1_b <= cur;
      end
      de_r <= s1_vld;
      if (s1_vld) do_r <= mix;
      hs_pipe <= {hs_pipe[1:0], bus.hs_i};
      vs_pipe <= {vs_pipe[1:0], bus.vs_i};
      err_r   <= ovf | (err_r & ~bus.vs_i);
    end
  end

  assign bus.do_o  = do_r;
  assign bus.de_o  = de_r;
  assign bus.hs_o  = hs_pipe[2];
  assign bus.vs_o  = vs_pipe[2];
  assign bus.err_o = err_r;
endmodule

// File: tb/tb_scaler_h_mch.sv
// Directed bench for scaler_h_mch: single-channel and three-channel instances fed the same stream.
module tb_scaler_h_mch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] step;
  logic [23:0] di;
  logic        de, hs, vs;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  cap[$];
  int          cap_cyc[$];
  logic [23:0] cap3[$];
  int          hs_cyc[$];

  int          b, b3, hb, h_c, p0c;
  int          exp_dn[4] = '{0, 2, 4, 6};
  int          exp_up[5] = '{0, 5, 10, 15, 20};
  logic [23:0] exp_mc[3] = '{24'h1E140A, 24'h3C2814, 24'h5A3C1E};

  scaler_h_mch_if #(.CHANNELS(1)) bus  ();
  scaler_h_mch_if #(.CHANNELS(3)) bus3 ();

  assign bus.scale_step  = step;
  assign bus.di_i        = di[7:0];
  assign bus.de_i        = de;
  assign bus.hs_i        = hs;
  assign bus.vs_i        = vs;
  assign bus3.scale_step = step;
  assign bus3.di_i       = di;
  assign bus3.de_i       = de;
  assign bus3.hs_i       = hs;
  assign bus3.vs_i       = vs;

  scaler_h_mch #(.CHANNELS(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  scaler_h_mch #(.CHANNELS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.de_o) begin
      cap.push_back(bus.do_o);
      cap_cyc.push_back(cyc);
    end
    if (bus3.de_o) cap3.push_back(bus3.do_o);
    if (bus.hs_o)  hs_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int s, input logic v);
    step = 16'(s);
    hs   = 1'b1;
    vs   = v;
    tick();
    hs   = 1'b0;
    vs   = 1'b0;
  endtask

  task automatic send(input logic [23:0] d);
    di = d;
    de = 1'b1;
    tick();
    de = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    step  = 16'd128;
    di    = '0;
    de    = 1'b0;
    hs    = 1'b0;
    vs    = 1'b0;
    idle(3);
    chk("reset_out", {bus.do_o, bus.de_o, bus.hs_o, bus.vs_o, bus.err_o}, 32'd0);
    chk("reset_out3", {bus3.do_o, bus3.de_o, bus3.err_o}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // identity, back-to-back
    b = cap.size(); hb = hs_cyc.size(); h_c = cyc;
    start_line(128, 1'b1);
    p0c = cyc;
    for (int i = 0; i < 8; i++) send(24'(i));
    idle(8);
    chk("ident_count", cap.size() - b, 8);
    chk("ident_latency", cap_cyc[b] - p0c, 3);
    chk("hs_latency", hs_cyc[hb] - h_c, 3);
    for (int i = 0; i < 8; i++) chk("ident_val", 32'(cap[b+i]), 32'(i));
    chk("ident_err", bus.err_o, 0);

    // downscale by 2 on a ramp
    b = cap.size();
    start_line(256, 1'b1);
    for (int i = 0; i < 8; i++) send(24'(i));
    idle(8);
    chk("down2_count", cap.size() - b, 4);
    for (int i = 0; i < 4; i++) chk("down2_val", 32'(cap[b+i]), 32'(exp_dn[i]));

    // fractional downscale on flat image: positions 0,179,...,895
    b = cap.size();
    start_line(179, 1'b1);
    for (int i = 0; i < 8; i++) send(24'd100);
    idle(8);
    chk("down179_count", cap.size() - b, 6);
    for (int i = 0; i < 6; i++) chk("down179_val", 32'(cap[b+i]), 100);

    // upscale by 2 with gaps
    b = cap.size();
    start_line(64, 1'b1);
    send(24'd0);  idle(3);
    send(24'd10); idle(3);
    send(24'd20); idle(8);
    chk("up2_count", cap.size() - b, 5);
    for (int i = 0; i < 5; i++) chk("up2_val", 32'(cap[b+i]), 32'(exp_up[i]));
    chk("up2_err", bus.err_o, 0);

    // three channels share one weight
    b3 = cap3.size();
    start_line(64, 1'b1);
    send({8'd30, 8'd20, 8'd10}); idle(3);
    send({8'd90, 8'd60, 8'd30}); idle(8);
    chk("mc_count", cap3.size() - b3, 3);
    for (int i = 0; i < 3; i++) chk("mc_val", 32'(cap3[b3+i]), 32'(exp_mc[i]));

    // overflow at 4x upscale, sticky until the next frame start
    start_line(32, 1'b1);
    for (int i = 0; i < 8; i++) send(24'(i * 8));
    chk("ovf_set", bus.err_o, 1);
    idle(40);
    chk("ovf_hold", bus.err_o, 1);
    start_line(128, 1'b0);
    chk("ovf_hs_only", bus.err_o, 1);
    start_line(128, 1'b1);
    chk("ovf_vs_clear", bus.err_o, 0);

    // reset in the middle of emission
    start_line(32, 1'b1);
    for (int i = 0; i < 5; i++) send(24'(50 + i));
    chk("pre_rst_err", bus.err_o, 1);
    chk("pre_rst_de", bus.de_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {bus.do_o, bus.de_o, bus.hs_o, bus.vs_o, bus.err_o}, 32'd0);
    chk("rst_async3", {bus3.do_o, bus3.de_o, bus3.err_o}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    b = cap.size();
    for (int i = 0; i < 3; i++) send(24'd7);
    idle(8);
    chk("rst_no_hs_out", cap.size() - b, 0);
    b = cap.size();
    start_line(128, 1'b1);
    send(24'd40); send(24'd41); send(24'd42);
    idle(8);
    chk("post_rst_count", cap.size() - b, 3);
    for (int i = 0; i < 3; i++) chk("post_rst_val", 32'(cap[b+i]), 32'(40 + i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
